// File: rtl/mai_back_addr_gen.sv
// ---------------------------------------------------------------------------
// mai_back_addr_gen
//
// Upstream address generator for the background sprite stage. Converts the
// VGA scan position into the 16-bit background ROM address. The background
// image is shown 2x upscaled and scrolled horizontally by a per-frame camera
// state machine that slews the scroll offset toward a game-supplied target.
// Row addressing is incremental (one add of IMG_W every second line), so no
// multiplier is needed.
//
// Build option:
//   MAI_BACK_SCROLL_EN  defined   -> camera scroll FSM active
//                       undefined -> scroll fixed at MAX_SCROLL/2, pan HOLD,
//                                    cam_x/frame_start ignored
//
// Ports:
//   vga_clk      in   1   pixel clock, all state changes on posedge
//   reset        in   1   synchronous, active-high
//   DrawX        in  10   current column 0..799
//   DrawY        in  10   current line 0..524
//   frame_start  in   1   one-cycle pulse per frame (vertical blank)
//   cam_x        in   9   target scroll offset in image pixels
//   rom_address  out 16   background ROM address (1-cycle latency)
//   bg_active    out  1   pixel lies inside the background window
//   scroll_x     out  9   current scroll offset
//   pan_state    out  2   00 HOLD, 01 PAN_RIGHT, 10 PAN_LEFT
// ---------------------------------------------------------------------------
module mai_back_addr_gen #(
    parameter int IMG_W       = 384,
    parameter int IMG_H       = 160,
    parameter int VIEW_W      = 320,
    parameter int SCROLL_STEP = 4
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_start,
    input  logic [8:0]  cam_x,
    output logic [15:0] rom_address,
    output logic        bg_active,
    output logic [8:0]  scroll_x,
    output logic [1:0]  pan_state
);

    localparam int         MAX_SCROLL   = IMG_W - VIEW_W;
    localparam logic [8:0] MAX_SCROLL_V = 9'(MAX_SCROLL);
    localparam logic [8:0] SCROLL_INIT  = 9'(MAX_SCROLL / 2);
    localparam logic [8:0] STEP_V       = 9'(SCROLL_STEP);
    localparam logic [15:0] ROW_STRIDE  = 16'(IMG_W);
    localparam logic [9:0] WIN_W        = 10'd640;
    localparam logic [9:0] WIN_H        = 10'(2 * IMG_H);

    typedef enum logic [1:0] {
        HOLD      = 2'b00,
        PAN_RIGHT = 2'b01,
        PAN_LEFT  = 2'b10
    } pan_state_e;

    logic [15:0] row_base_q;
    logic [15:0] row_base_d;
    logic [15:0] rom_address_q;
    logic        bg_active_q;
    logic [8:0]  scroll_q;
    pan_state_e  pan_q;
    logic        inWindow;
    logic [15:0] pixelAddr;

    // Row base steps by one image row every second screen line, since each
    // image row is shown twice. The value computed at DrawX == 0 is used
    // straight away so column 0 of a new line already addresses the new row.
    always_comb begin
        row_base_d = row_base_q;
        if (DrawX == 10'd0) begin
            if (DrawY == 10'd0) begin
                row_base_d = 16'd0;
            end else if (!DrawY[0] && (DrawY < WIN_H)) begin
                row_base_d = row_base_q + ROW_STRIDE;
            end
        end
    end

    // Window decode and pixel address; DrawX[9:1] undoes the 2x upscale.
    always_comb begin
        inWindow  = (DrawX < WIN_W) && (DrawY < WIN_H);
        pixelAddr = row_base_d + 16'(scroll_q) + 16'(DrawX[9:1]);
    end

    // Address pipeline register: outputs lag the scan position by one cycle.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            row_base_q    <= 16'd0;
            rom_address_q <= 16'd0;
            bg_active_q   <= 1'b0;
        end else begin
            row_base_q    <= row_base_d;
            rom_address_q <= inWindow ? pixelAddr : 16'd0;
            bg_active_q   <= inWindow;
        end
    end

`ifdef MAI_BACK_SCROLL_EN
    logic [8:0] target;
    logic [8:0] stepUp;
    logic [8:0] stepDown;
    logic [8:0] scroll_d;
    pan_state_e pan_d;

    // Next scroll offset: move toward the clamped target by at most one
    // step. Direction is re-decided every frame from the target alone, so a
    // reversal mid-pan simply flips direction and can never overshoot.
    always_comb begin
        target   = (cam_x > MAX_SCROLL_V) ? MAX_SCROLL_V : cam_x;
        stepUp   = ((target - scroll_q) > STEP_V) ? STEP_V : (target - scroll_q);
        stepDown = ((scroll_q - target) > STEP_V) ? STEP_V : (scroll_q - target);
        scroll_d = scroll_q;
        pan_d    = HOLD;
        if (target > scroll_q) begin
            scroll_d = scroll_q + stepUp;
            pan_d    = (scroll_d == target) ? HOLD : PAN_RIGHT;
        end else if (target < scroll_q) begin
            scroll_d = scroll_q - stepDown;
            pan_d    = (scroll_d == target) ? HOLD : PAN_LEFT;
        end
    end

    // Camera FSM: only advances on the frame_start pulse, so the offset is
    // constant across every visible frame.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            scroll_q <= SCROLL_INIT;
            pan_q    <= HOLD;
        end else if (frame_start) begin
            scroll_q <= scroll_d;
            pan_q    <= pan_d;
        end
    end
`else
    logic unusedScrollInputs;

    // Fixed camera: offset parked in the middle of the scroll range.
    assign scroll_q           = SCROLL_INIT;
    assign pan_q              = HOLD;
    assign unusedScrollInputs = frame_start ^ (^cam_x);
`endif

    assign rom_address = rom_address_q;
    assign bg_active   = bg_active_q;
    assign scroll_x    = scroll_q;
    assign pan_state   = pan_q;

endmodule

// File: tb/tb_mai_back_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_mai_back_addr_gen
//
// Self-checking bench for mai_back_addr_gen. A fixed vector table covers the
// basic address path; hand-written sequences cover full-height row stepping,
// window edges, camera panning, clamping, reversal and mid-line reset.
// Expected addresses are queued when stimulus is driven and popped when the
// registered output is due.
// ---------------------------------------------------------------------------
module tb_mai_back_addr_gen;

    logic        vga_clk;
    logic        reset;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        frame_start;
    logic [8:0]  cam_x;
    logic [15:0] rom_address;
    logic        bg_active;
    logic [8:0]  scroll_x;
    logic [1:0]  pan_state;

    int testCount = 0;
    int failCount = 0;

    typedef struct packed {
        logic [15:0] rom;
        logic        act;
    } exp_t;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] rom;
        logic        act;
    } vec_t;

    exp_t expQ[$];
    vec_t vecs[15];

    // Reference state for the model-driven sequences
    logic [15:0] mRowBase;
    logic [8:0]  mScroll;
    logic [1:0]  mPan;

    mai_back_addr_gen dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .frame_start (frame_start),
        .cam_x       (cam_x),
        .rom_address (rom_address),
        .bg_active   (bg_active),
        .scroll_x    (scroll_x),
        .pan_state   (pan_state)
    );

    // Free-running pixel clock
    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    // Pop the oldest expectation and compare it with the registered outputs
    task automatic checkOutput(input string name);
        exp_t e;
        testCount++;
        if (expQ.size() == 0) begin
            failCount++;
            $display("[TB] FAIL %s: scoreboard empty, got rom=%0d act=%0b", name, rom_address, bg_active);
        end else begin
            e = expQ.pop_front();
            if (rom_address !== e.rom) begin
                failCount++;
                $display("[TB] FAIL %s rom_address: got %0d expected %0d", name, rom_address, e.rom);
            end
            testCount++;
            if (bg_active !== e.act) begin
                failCount++;
                $display("[TB] FAIL %s bg_active: got %0b expected %0b", name, bg_active, e.act);
            end
        end
    endtask

    task automatic checkScroll(input string name, input logic [8:0] expScroll, input logic [1:0] expPan);
        testCount++;
        if (scroll_x !== expScroll) begin
            failCount++;
            $display("[TB] FAIL %s scroll_x: got %0d expected %0d", name, scroll_x, expScroll);
        end
        testCount++;
        if (pan_state !== expPan) begin
            failCount++;
            $display("[TB] FAIL %s pan_state: got %0b expected %0b", name, pan_state, expPan);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, check one cycle later
    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic fs,
                                 input logic [8:0] cam, input logic rst,
                                 input logic [15:0] expRom, input logic expAct, input string name);
        exp_t e;
        @(negedge vga_clk);
        DrawX       = x;
        DrawY       = y;
        frame_start = fs;
        cam_x       = cam;
        reset       = rst;
        e.rom       = expRom;
        e.act       = expAct;
        expQ.push_back(e);
        @(posedge vga_clk);
        #1;
        checkOutput(name);
    endtask

    // Camera behaviour as described for the scroll FSM
    task automatic modelScroll(input logic [8:0] cam);
`ifdef MAI_BACK_SCROLL_EN
        int t;
        int s;
        t = (cam > 9'd64) ? 64 : int'(cam);
        s = int'(mScroll);
        if (t > s) begin
            s    = s + (((t - s) > 4) ? 4 : (t - s));
            mPan = (s == t) ? 2'b00 : 2'b01;
        end else if (t < s) begin
            s    = s - (((s - t) > 4) ? 4 : (s - t));
            mPan = (s == t) ? 2'b00 : 2'b10;
        end else begin
            mPan = 2'b00;
        end
        mScroll = 9'(s);
`else
        mScroll = 9'd32;
        mPan    = 2'b00;
        if (cam == 9'h1ff) mPan = 2'b00;
`endif
    endtask

    // One model-checked cycle: address, active flag, scroll and pan state
    task automatic runCycle(input logic [9:0] x, input logic [9:0] y, input logic fs,
                            input logic [8:0] cam, input logic rst, input string name);
        logic [15:0] rbNext;
        logic [15:0] er;
        logic        ea;
        rbNext = mRowBase;
        if (x == 10'd0) begin
            if (y == 10'd0) rbNext = 16'd0;
            else if (!y[0] && (y < 10'd320)) rbNext = mRowBase + 16'd384;
        end
        ea = (x < 10'd640) && (y < 10'd320);
        er = ea ? (rbNext + 16'(mScroll) + 16'(x >> 1)) : 16'd0;
        if (rst) begin
            ea       = 1'b0;
            er       = 16'd0;
            mRowBase = 16'd0;
            mScroll  = 9'd32;
            mPan     = 2'b00;
        end else begin
            mRowBase = rbNext;
            if (fs) modelScroll(cam);
        end
        applyStimulus(x, y, fs, cam, rst, er, ea, name);
        checkScroll(name, mScroll, mPan);
    endtask

    initial begin
        reset       = 1'b1;
        DrawX       = 10'd0;
        DrawY       = 10'd0;
        frame_start = 1'b0;
        cam_x       = 9'd0;
        mRowBase    = 16'd0;
        mScroll     = 9'd32;
        mPan        = 2'b00;

        // Basic address path after reset, scroll at its reset value of 32
        vecs[0]  = '{x: 10'd0,   y: 10'd0,   rom: 16'd32,  act: 1'b1};
        vecs[1]  = '{x: 10'd1,   y: 10'd0,   rom: 16'd32,  act: 1'b1};
        vecs[2]  = '{x: 10'd2,   y: 10'd0,   rom: 16'd33,  act: 1'b1};
        vecs[3]  = '{x: 10'd639, y: 10'd0,   rom: 16'd351, act: 1'b1};
        vecs[4]  = '{x: 10'd0,   y: 10'd1,   rom: 16'd32,  act: 1'b1};
        vecs[5]  = '{x: 10'd5,   y: 10'd1,   rom: 16'd34,  act: 1'b1};
        vecs[6]  = '{x: 10'd0,   y: 10'd2,   rom: 16'd416, act: 1'b1};
        vecs[7]  = '{x: 10'd700, y: 10'd2,   rom: 16'd0,   act: 1'b0};
        vecs[8]  = '{x: 10'd10,  y: 10'd2,   rom: 16'd421, act: 1'b1};
        vecs[9]  = '{x: 10'd0,   y: 10'd320, rom: 16'd0,   act: 1'b0};
        vecs[10] = '{x: 10'd3,   y: 10'd2,   rom: 16'd417, act: 1'b1};
        vecs[11] = '{x: 10'd0,   y: 10'd3,   rom: 16'd416, act: 1'b1};
        vecs[12] = '{x: 10'd0,   y: 10'd4,   rom: 16'd800, act: 1'b1};
        vecs[13] = '{x: 10'd799, y: 10'd524, rom: 16'd0,   act: 1'b0};
        vecs[14] = '{x: 10'd0,   y: 10'd0,   rom: 16'd32,  act: 1'b1};

        // Reset state
        runCycle(10'd0, 10'd0, 1'b0, 9'd0, 1'b1, "reset0");
        runCycle(10'd0, 10'd0, 1'b0, 9'd0, 1'b1, "reset1");

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, 1'b0, 9'd0, 1'b0,
                          vecs[i].rom, vecs[i].act, $sformatf("vec%0d", i));
        end
        mRowBase = 16'd0;
        checkScroll("tableScroll", 9'd32, 2'b00);

        // Column 0 of every visible line, then the last visible pixel
        for (int y = 0; y < 320; y++) begin
            runCycle(10'd0, 10'(y), 1'b0, 9'd0, 1'b0, $sformatf("row%0d", y));
        end
        applyStimulus(10'd639, 10'd319, 1'b0, 9'd0, 1'b0, 16'd61407, 1'b1, "lastPixel");
        runCycle(10'd639, 10'd319, 1'b0, 9'd0, 1'b0, "lastPixelModel");
        runCycle(10'd0, 10'd320, 1'b0, 9'd0, 1'b0, "belowWindow");
        runCycle(10'd700, 10'd100, 1'b0, 9'd0, 1'b0, "rightOfWindow");
        runCycle(10'd4, 10'd319, 1'b0, 9'd0, 1'b0, "rowBaseHeld");

        // Pan right to the limit; offset must not move between pulses
        for (int k = 0; k < 9; k++) begin
            runCycle(10'd5, 10'd400, 1'b1, 9'd64, 1'b0, $sformatf("panR%0d", k));
            runCycle(10'd6, 10'd401, 1'b0, 9'd0, 1'b0, $sformatf("panRgap%0d", k));
        end
        runCycle(10'd5, 10'd400, 1'b1, 9'd200, 1'b0, "clamp200");

        // New offset reaches the address path on the next frame
        runCycle(10'd0, 10'd0, 1'b0, 9'd0, 1'b0, "scrollAddr0");
        runCycle(10'd9, 10'd0, 1'b0, 9'd0, 1'b0, "scrollAddr9");

        // Pan left down to 33, then a 3-pixel final step to 30
        for (int k = 0; k < 8; k++) begin
            runCycle(10'd5, 10'd400, 1'b1, 9'd33, 1'b0, $sformatf("panL%0d", k));
        end
        runCycle(10'd5, 10'd400, 1'b1, 9'd30, 1'b0, "shortStep");
        runCycle(10'd5, 10'd400, 1'b1, 9'd30, 1'b0, "holdAt30");

        // Reversal mid-pan must not overshoot
        runCycle(10'd5, 10'd400, 1'b1, 9'd64, 1'b0, "revUp");
        runCycle(10'd5, 10'd400, 1'b1, 9'd64, 1'b0, "revUp2");
        runCycle(10'd5, 10'd400, 1'b1, 9'd35, 1'b0, "revDown");
        runCycle(10'd5, 10'd400, 1'b1, 9'd35, 1'b0, "revDown2");

        // Reach 48, with frame_start landing on a DrawX == 0 cycle
        for (int k = 0; k < 4; k++) begin
            runCycle(10'd0, 10'd0, 1'b1, 9'd48, 1'b0, $sformatf("to48_%0d", k));
        end
        runCycle(10'd1, 10'd0, 1'b0, 9'd48, 1'b0, "after48");

        // Reset for one cycle mid-line
        runCycle(10'd100, 10'd10, 1'b0, 9'd48, 1'b0, "preReset");
        runCycle(10'd101, 10'd10, 1'b0, 9'd48, 1'b1, "midReset");
        runCycle(10'd0, 10'd0, 1'b0, 9'd48, 1'b0, "postReset0");
        runCycle(10'd0, 10'd2, 1'b0, 9'd48, 1'b0, "postReset2");

        // Ten frames requesting the right edge
        for (int k = 0; k < 10; k++) begin
            runCycle(10'd5, 10'd400, 1'b1, 9'd64, 1'b0, $sformatf("frame%0d", k));
        end

        testCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboardDrain: %0d entries left, expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
